// File: rtl/redmule_instr_axi_slv_if.sv
// redmule_instr_axi_slv_if
//   Bundles the instruction-fetch AXI4 channels (AR, R, AW, W, B) and the
//   instruction-SRAM read port of redmule_instr_axi_slv.
//   Modports:
//     slave  - the AXI slave (drives ready/R/B/mem_req/mem_addr).
//     master - the environment: core-side AXI master plus SRAM model.
//
//   Handshake rule on every channel: a beat transfers on a rising clock edge
//   where both valid and ready are 1. Once valid is raised, the payload stays
//   stable and valid stays high until that transfer edge. ready may depend on
//   valid; valid never depends on ready.
//   The SRAM port has no handshake: mem_req is always granted and mem_rdata
//   is valid in the cycle after mem_req.
interface redmule_instr_axi_slv_if #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned MEM_ADDR_WIDTH = 12
);
    logic                      ar_valid_i;
    logic                      ar_ready_o;
    logic [ID_WIDTH-1:0]       ar_id_i;
    logic [ADDR_WIDTH-1:0]     ar_addr_i;
    logic [7:0]                ar_len_i;
    logic [2:0]                ar_size_i;
    logic [1:0]                ar_burst_i;

    logic                      r_valid_o;
    logic                      r_ready_i;
    logic [ID_WIDTH-1:0]       r_id_o;
    logic [DATA_WIDTH-1:0]     r_data_o;
    logic [1:0]                r_resp_o;
    logic                      r_last_o;

    logic                      aw_valid_i;
    logic                      aw_ready_o;
    logic [ID_WIDTH-1:0]       aw_id_i;

    logic                      w_valid_i;
    logic                      w_ready_o;
    logic                      w_last_i;

    logic                      b_valid_o;
    logic                      b_ready_i;
    logic [ID_WIDTH-1:0]       b_id_o;
    logic [1:0]                b_resp_o;

    logic                      mem_req_o;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0]     mem_rdata_i;

    modport slave (
        input  ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
        output ar_ready_o,
        output r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
        input  r_ready_i,
        input  aw_valid_i, aw_id_i,
        output aw_ready_o,
        input  w_valid_i, w_last_i,
        output w_ready_o,
        output b_valid_o, b_id_o, b_resp_o,
        input  b_ready_i,
        output mem_req_o, mem_addr_o,
        input  mem_rdata_i
    );

    modport master (
        output ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
        input  ar_ready_o,
        input  r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
        output r_ready_i,
        output aw_valid_i, aw_id_i,
        input  aw_ready_o,
        output w_valid_i, w_last_i,
        input  w_ready_o,
        input  b_valid_o, b_id_o, b_resp_o,
        output b_ready_i,
        input  mem_req_o, mem_addr_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/redmule_instr_axi_slv.sv
// redmule_instr_axi_slv
//   AXI4 slave serving instruction fetches from a single-port, read-latency-1
//   SRAM. INCR and FIXED read bursts are served; WRAP/reserved bursts or a
//   size other than the full bus width return SLVERR beats with zero data.
//   Every write is accepted and answered with one SLVERR B beat.
//   Ports:
//     clk_i, rst_ni   - clock, synchronous active-low reset
//     bus (slave)     - AR/R/AW/W/B channels and SRAM read port
//     dbg_rd_state_o  - read FSM state (0 idle, 1 burst)
//     dbg_wr_state_o  - write FSM state (0 idle, 1 data, 2 resp)
//   Optional feature macro: REDMULE_INSTR_SLV_RANGE_CHECK_EN
//     When defined, a read whose word index does not fit in MEM_ADDR_WIDTH
//     returns DECERR on every beat and never touches the SRAM. When undefined
//     the index is truncated and wraps into the SRAM.
module redmule_instr_axi_slv #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned MEM_ADDR_WIDTH = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    redmule_instr_axi_slv_if.slave bus,
    output logic                   dbg_rd_state_o,
    output logic [1:0]             dbg_wr_state_o
);
    localparam int unsigned OFFSET = $clog2(DATA_WIDTH / 8);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic {RD_IDLE = 1'b0, RD_BURST = 1'b1} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_DATA = 2'd1, WR_RESP = 2'd2} wr_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
        logic [1:0]            resp;
        logic                  last;
    } beat_t;

    // Read issue side
    rd_state_e                 rd_state;
    logic [ID_WIDTH-1:0]       rd_id;
    logic [1:0]                rd_resp;
    logic                      rd_fixed;
    logic [MEM_ADDR_WIDTH-1:0] word_idx;
    logic [7:0]                beats_left;
    logic [MEM_ADDR_WIDTH-1:0] ar_idx;
    logic [1:0]                ar_resp;
    logic                      credit;
    logic                      issue;

    // Beat in flight through the SRAM (issued last cycle)
    logic                      p_valid;
    logic [ID_WIDTH-1:0]       p_id;
    logic [1:0]                p_resp;
    logic                      p_last;

    // 2-entry response FIFO with fall-through when empty
    beat_t                     fifo_q [2];
    logic                      wptr, rptr;
    logic [1:0]                fifo_cnt;
    beat_t                     in_beat, head;
    logic                      r_valid, r_hs, push, pop;

    // Write side
    wr_state_e                 wr_state;
    logic [ID_WIDTH-1:0]       wr_id;

    always_comb begin
        ar_idx  = MEM_ADDR_WIDTH'(bus.ar_addr_i >> OFFSET);
        ar_resp = RESP_OKAY;
        if ((bus.ar_burst_i != BURST_FIXED && bus.ar_burst_i != BURST_INCR) ||
            bus.ar_size_i != 3'(OFFSET))
            ar_resp = RESP_SLVERR;
`ifdef REDMULE_INSTR_SLV_RANGE_CHECK_EN
        if (((bus.ar_addr_i >> OFFSET) >> MEM_ADDR_WIDTH) != '0)
            ar_resp = RESP_DECERR;
`endif
    end

    // Credit counts the beat still inside the SRAM so that at most two beats
    // are ever outstanding; this is what keeps the FIFO from overflowing.
    assign credit = ({1'b0, fifo_cnt} + {2'b00, p_valid}) < 3'd2;
    assign issue  = (rd_state == RD_BURST) && credit;

    always_comb begin
        in_beat.data = (p_resp == RESP_OKAY) ? bus.mem_rdata_i : '0;
        in_beat.id   = p_id;
        in_beat.resp = p_resp;
        in_beat.last = p_last;
        // The SRAM output bypasses the storage when nothing is queued ahead.
        head    = (fifo_cnt != 2'd0) ? fifo_q[rptr] : in_beat;
        r_valid = (fifo_cnt != 2'd0) || p_valid;
        r_hs    = r_valid && bus.r_ready_i;
        pop     = (fifo_cnt != 2'd0) && r_hs;
        push    = p_valid && !((fifo_cnt == 2'd0) && r_hs);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_state   <= RD_IDLE;
            rd_id      <= '0;
            rd_resp    <= RESP_OKAY;
            rd_fixed   <= 1'b0;
            word_idx   <= '0;
            beats_left <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (bus.ar_valid_i) begin
                        rd_id      <= bus.ar_id_i;
                        rd_resp    <= ar_resp;
                        rd_fixed   <= (bus.ar_burst_i == BURST_FIXED);
                        word_idx   <= ar_idx;
                        beats_left <= bus.ar_len_i;
                        rd_state   <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (credit) begin
                        if (beats_left == 8'd0) begin
                            rd_state <= RD_IDLE;
                        end else begin
                            beats_left <= beats_left - 8'd1;
                            if (!rd_fixed) word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            p_valid  <= 1'b0;
            p_id     <= '0;
            p_resp   <= RESP_OKAY;
            p_last   <= 1'b0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            fifo_cnt <= 2'd0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            p_valid <= issue;
            p_id    <= rd_id;
            p_resp  <= rd_resp;
            p_last  <= (beats_left == 8'd0);
            if (push) begin
                fifo_q[wptr] <= in_beat;
                wptr         <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_state <= WR_IDLE;
            wr_id    <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: if (bus.aw_valid_i) begin
                    wr_id    <= bus.aw_id_i;
                    wr_state <= WR_DATA;
                end
                WR_DATA: if (bus.w_valid_i && bus.w_last_i) wr_state <= WR_RESP;
                WR_RESP: if (bus.b_ready_i) wr_state <= WR_IDLE;
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // All outputs are forced low while reset is held.
    always_comb begin
        bus.ar_ready_o = rst_ni && (rd_state == RD_IDLE);
        bus.r_valid_o  = rst_ni && r_valid;
        bus.r_data_o   = bus.r_valid_o ? head.data : '0;
        bus.r_id_o     = bus.r_valid_o ? head.id   : '0;
        bus.r_resp_o   = bus.r_valid_o ? head.resp : RESP_OKAY;
        bus.r_last_o   = bus.r_valid_o && head.last;
        bus.mem_req_o  = rst_ni && issue && (rd_resp == RESP_OKAY);
        bus.mem_addr_o = rst_ni ? word_idx : '0;
        bus.aw_ready_o = rst_ni && (wr_state == WR_IDLE);
        bus.w_ready_o  = rst_ni && (wr_state == WR_DATA);
        bus.b_valid_o  = rst_ni && (wr_state == WR_RESP);
        bus.b_id_o     = bus.b_valid_o ? wr_id : '0;
        bus.b_resp_o   = bus.b_valid_o ? RESP_SLVERR : RESP_OKAY;
        dbg_rd_state_o = rst_ni && (rd_state == RD_BURST);
        dbg_wr_state_o = rst_ni ? wr_state : WR_IDLE;
    end
endmodule

// File: tb/tb_redmule_instr_axi_slv.sv
`timescale 1ns/1ps
module tb_redmule_instr_axi_slv;
  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned DATA_WIDTH     = 64;
  localparam int unsigned ID_WIDTH       = 4;
  localparam int unsigned MEM_ADDR_WIDTH = 12;
  localparam int unsigned DEPTH          = 1 << MEM_ADDR_WIDTH;
  localparam int unsigned BW             = DATA_WIDTH + ID_WIDTH + 3;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [1:0]  DECERR = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       dbg_rd_state;
  logic [1:0] dbg_wr_state;

  redmule_instr_axi_slv_if #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .ID_WIDTH(ID_WIDTH), .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) bus ();

  redmule_instr_axi_slv #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .ID_WIDTH(ID_WIDTH), .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .bus(bus),
    .dbg_rd_state_o(dbg_rd_state),
    .dbg_wr_state_o(dbg_wr_state)
  );

  // ---------------- SRAM model ----------------
  logic [DATA_WIDTH-1:0] sram [DEPTH];
  always @(posedge clk_i) begin
    if (bus.mem_req_o) bus.mem_rdata_i <= sram[bus.mem_addr_o];
  end

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [BW-1:0]             exp_q[$];
  logic [MEM_ADDR_WIDTH-1:0] addr_q[$];
  logic [ID_WIDTH-1:0]       exp_b_q[$];
  int   n_r_beats  = 0;
  bit   rand_ready = 1'b0;
  bit   force_ready = 1'b1;
  bit   w_open = 1'b0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int val);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %0d expected none", name, val);
  endtask

  // Reference model: expected beats of a read burst derived from the AXI rules.
  task automatic model_read(input logic [ID_WIDTH-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int unsigned word;
    int unsigned idx;
    logic [1:0] resp;
    logic [DATA_WIDTH-1:0] data;
    word = addr / (DATA_WIDTH / 8);
    resp = OKAY;
    if (burst == 2'b10 || burst == 2'b11 || size != 3'd3) resp = SLVERR;
`ifdef REDMULE_INSTR_SLV_RANGE_CHECK_EN
    if (word >= DEPTH) resp = DECERR;
`endif
    for (int i = 0; i <= int'(len); i++) begin
      idx  = (burst == 2'b01) ? (word + i) % DEPTH : word % DEPTH;
      data = (resp == OKAY) ? sram[idx] : '0;
      exp_q.push_back({data, id, resp, (i == int'(len))});
      if (resp == OKAY) addr_q.push_back(MEM_ADDR_WIDTH'(idx));
    end
  endtask

  // ---------------- ready drivers ----------------
  always @(posedge clk_i) begin
    #1;
    bus.r_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
    bus.b_ready_i = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
  end

  // ---------------- monitor ----------------
  bit            stall_prev = 1'b0;
  logic [BW-1:0] stall_pay;
  always @(negedge clk_i) begin
    logic [BW-1:0] act;
    if (!rst_ni) begin
      stall_prev = 1'b0;
    end else begin
      act = {bus.r_data_o, bus.r_id_o, bus.r_resp_o, bus.r_last_o};
      if (stall_prev) begin
        check("r_valid_hold", BW'(bus.r_valid_o), BW'(1));
        check("r_payload_stable", act, stall_pay);
      end
      if (bus.r_valid_o && bus.r_ready_i) begin
        if (exp_q.size() == 0) fail_now("r_unexpected_beat", n_r_beats);
        else check("r_beat", act, exp_q.pop_front());
        n_r_beats++;
      end
      stall_prev = bus.r_valid_o && !bus.r_ready_i;
      stall_pay  = act;
      if (bus.mem_req_o) begin
        if (addr_q.size() == 0) fail_now("mem_req_unexpected", int'(bus.mem_addr_o));
        else check("mem_addr", BW'(bus.mem_addr_o), BW'(addr_q.pop_front()));
      end
      if (bus.b_valid_o) check("b_after_wlast", BW'(w_open), BW'(0));
      if (bus.b_valid_o && bus.b_ready_i) begin
        if (exp_b_q.size() == 0) fail_now("b_unexpected", int'(bus.b_id_o));
        else check("b_beat", BW'({bus.b_id_o, bus.b_resp_o}), BW'({exp_b_q.pop_front(), SLVERR}));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_ar(input logic [ID_WIDTH-1:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    bit hs = 1'b0;
    bus.ar_valid_i = 1'b1;
    bus.ar_id_i    = id;
    bus.ar_addr_i  = addr;
    bus.ar_len_i   = len;
    bus.ar_size_i  = size;
    bus.ar_burst_i = burst;
    for (int t = 0; t < 500 && !hs; t++) begin
      @(negedge clk_i);
      hs = bus.ar_ready_o;
      @(posedge clk_i);
      #1;
    end
    bus.ar_valid_i = 1'b0;
    if (!hs) fail_now("ar_timeout", 500);
    else model_read(id, addr, len, size, burst);
  endtask

  task automatic do_write(input logic [ID_WIDTH-1:0] id, input int nbeats, input bit rnd);
    bit hs = 1'b0;
    bus.aw_valid_i = 1'b1;
    bus.aw_id_i    = id;
    for (int t = 0; t < 500 && !hs; t++) begin
      @(negedge clk_i);
      hs = bus.aw_ready_o;
      @(posedge clk_i);
      #1;
    end
    bus.aw_valid_i = 1'b0;
    if (!hs) begin
      fail_now("aw_timeout", 500);
      return;
    end
    exp_b_q.push_back(id);
    w_open = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      bus.w_valid_i = 1'b1;
      bus.w_last_i  = (b == nbeats - 1);
      hs = 1'b0;
      for (int t = 0; t < 500 && !hs; t++) begin
        @(negedge clk_i);
        hs = bus.w_ready_o;
        @(posedge clk_i);
        #1;
      end
      bus.w_valid_i = 1'b0;
      bus.w_last_i  = 1'b0;
      if (!hs) fail_now("w_timeout", b);
    end
    w_open = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0 || exp_b_q.size() != 0) && t < 3000) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    check("drain_empty", BW'(exp_q.size() + addr_q.size() + exp_b_q.size()), '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ar_ready"}, BW'(bus.ar_ready_o), '0);
    check({tag, "_r_valid"},  BW'(bus.r_valid_o),  '0);
    check({tag, "_aw_ready"}, BW'(bus.aw_ready_o), '0);
    check({tag, "_w_ready"},  BW'(bus.w_ready_o),  '0);
    check({tag, "_b_valid"},  BW'(bus.b_valid_o),  '0);
    check({tag, "_mem_req"},  BW'(bus.mem_req_o),  '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int reqs;
    bus.ar_valid_i = 1'b0; bus.ar_id_i = '0; bus.ar_addr_i = '0;
    bus.ar_len_i = '0; bus.ar_size_i = '0; bus.ar_burst_i = '0;
    bus.r_ready_i = 1'b0; bus.aw_valid_i = 1'b0; bus.aw_id_i = '0;
    bus.w_valid_i = 1'b0; bus.w_last_i = 1'b0; bus.b_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
    for (int i = 0; i < int'(DEPTH); i++) sram[i] = {$urandom, $urandom};
    sram[4] = 64'hDEADBEEF_CAFEF00D;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_reset_ar_ready", BW'(bus.ar_ready_o), BW'(1));
    check("post_reset_aw_ready", BW'(bus.aw_ready_o), BW'(1));
    @(posedge clk_i);
    #1;

    // Single read with latency check
    do_ar(4'd3, 32'h20, 8'd0, 3'd3, 2'b01);
    lat = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk_i);
      lat++;
      if (bus.r_valid_o) break;
    end
    check("single_rd_latency", BW'(lat), BW'(2));
    @(posedge clk_i);
    #1;
    drain();

    // INCR len 7: ar_ready back the cycle after the 8th issue
    do_ar(4'd1, 32'h0, 8'd7, 3'd3, 2'b01);
    lat = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk_i);
      lat++;
      if (bus.ar_ready_o) break;
    end
    check("incr_ar_ready_latency", BW'(lat), BW'(9));
    @(posedge clk_i);
    #1;
    drain();

    // Backpressure: stall R for 10 cycles after two beats
    n_r_beats = 0;
    do_ar(4'd2, 32'h0, 8'd7, 3'd3, 2'b01);
    for (int t = 0; t < 50 && n_r_beats < 2; t++) @(negedge clk_i);
    force_ready = 1'b0;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (i >= 2 && bus.mem_req_o) reqs++;
    end
    check("bp_mem_req_idle", BW'(reqs), '0);
    check("bp_r_valid_held", BW'(bus.r_valid_o), BW'(1));
    @(posedge clk_i);
    #1;
    force_ready = 1'b1;
    drain();
    check("bp_beat_count", BW'(n_r_beats), BW'(8));

    // FIXED, WRAP, write, range
    do_ar(4'd4, 32'h40, 8'd3, 3'd3, 2'b00);
    drain();
    do_ar(4'd6, 32'h80, 8'd3, 3'd3, 2'b10);
    drain();
    do_write(4'd5, 4, 1'b0);
    drain();
    do_ar(4'd7, 32'h8000, 8'd0, 3'd3, 2'b01);
    drain();

    // Reset asserted mid-burst
    do_ar(4'd8, 32'h100, 8'd15, 3'd3, 2'b01);
    repeat (4) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk_i);
    check_reset_outputs("midburst_reset");
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("midburst_release_ar_ready", BW'(bus.ar_ready_o), BW'(1));
    check("midburst_release_r_valid", BW'(bus.r_valid_o), '0);
    repeat (10) @(posedge clk_i);
    #1;

    // Randomized traffic, reads and writes in parallel
    rand_ready = 1'b1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic [1:0] burst;
          logic [2:0] size;
          int unsigned sel;
          sel   = $urandom_range(0, 9);
          burst = (sel < 5) ? 2'b01 : (sel < 8) ? 2'b00 : (sel == 8) ? 2'b10 : 2'b11;
          size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
          do_ar(4'($urandom), {$urandom_range(0, 2 * DEPTH - 1), 3'($urandom)},
                8'($urandom_range(0, 15)), size, burst);
          repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
        end
      end
      begin
        for (int n = 0; n < 10; n++) begin
          repeat ($urandom_range(0, 20)) begin @(posedge clk_i); #1; end
          do_write(4'($urandom), $urandom_range(1, 4), 1'b1);
        end
      end
    join
    drain();
    rand_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
